// File: rtl/rapcores_spi_pkg.sv
// Shared constants for the rapcores Wishbone-to-SPI bridge: register map, CTRL bits, FSM states.
package rapcores_spi_pkg;

    localparam int MAX_WORD_BITS = 64;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_TX0    = 3'd1;
    localparam logic [2:0] REG_TX1    = 3'd2;
    localparam logic [2:0] REG_RX0    = 3'd3;
    localparam logic [2:0] REG_RX1    = 3'd4;
    localparam logic [2:0] REG_CLKDIV = 3'd5;

    localparam int CTRL_START = 0;
    localparam int CTRL_DONE  = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD
    } spi_state_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/rapcores_spi_shifter.sv
// Mode-0, MSB-first SPI word engine; one transfer takes (div+1)*(2*WORD_BITS+2) cycles.
// START is only honoured in IDLE; rx updates once, when CS releases.
module rapcores_spi_shifter
    import rapcores_spi_pkg::*;
#(
    parameter int WORD_BITS = 64
) (
    input  logic                 wb_clk_i,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WORD_BITS-1:0] tx,
    input  logic [15:0]          div,
    input  logic                 spi_cipo_i,
    output logic                 busy,
    output logic [WORD_BITS-1:0] rx,
    output logic                 done_pulse,
    output logic                 spi_sck_o,
    output logic                 spi_cs_o,
    output logic                 spi_copi_o
);

    localparam int HW = $clog2(2*WORD_BITS);
    localparam logic [HW-1:0] LAST_HALF = HW'(2*WORD_BITS-1);

    spi_state_e           state, state_nxt;
    logic [15:0]          div_q, cnt;
    logic [HW-1:0]        half;
    logic [WORD_BITS-1:0] tx_sr, rx_sr;
    logic                 tick;

    assign tick = (cnt == 16'd0);
    assign busy = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start) state_nxt = ST_CS_SETUP;
            ST_CS_SETUP: if (tick) state_nxt = ST_SHIFT;
            ST_SHIFT:    if (tick && half == LAST_HALF) state_nxt = ST_CS_HOLD;
            ST_CS_HOLD:  if (tick) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            div_q      <= '0;
            cnt        <= '0;
            half       <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            rx         <= '0;
            done_pulse <= 1'b0;
            spi_sck_o  <= 1'b0;
            spi_cs_o   <= 1'b1;
            spi_copi_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            done_pulse <= 1'b0;
            if (state != ST_IDLE)
                cnt <= tick ? div_q : cnt - 16'd1;
            case (state)
                ST_IDLE: if (start) begin
                    tx_sr      <= tx;
                    div_q      <= div;
                    cnt        <= div;
                    half       <= '0;
                    rx_sr      <= '0;
                    spi_cs_o   <= 1'b0;
                    spi_copi_o <= tx[WORD_BITS-1];
                end
                ST_CS_SETUP: if (tick) begin
                    spi_sck_o <= 1'b1;
                    rx_sr     <= {rx_sr[WORD_BITS-2:0], spi_cipo_i};
                end
                ST_SHIFT: if (tick) begin
                    half <= half + 1'b1;
                    // even half-periods are SCK high, so their end is a falling edge
                    if (!half[0]) begin
                        spi_sck_o  <= 1'b0;
                        tx_sr      <= {tx_sr[WORD_BITS-2:0], 1'b0};
                        spi_copi_o <= tx_sr[WORD_BITS-2];
                    end else if (half != LAST_HALF) begin
                        spi_sck_o <= 1'b1;
                        rx_sr     <= {rx_sr[WORD_BITS-2:0], spi_cipo_i};
                    end
                end
                ST_CS_HOLD: if (tick) begin
                    spi_cs_o   <= 1'b1;
                    spi_copi_o <= 1'b0;
                    rx         <= rx_sr;
                    done_pulse <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rapcores_spi_master.sv
// Wishbone register file in front of the SPI shifter; every access acks exactly one cycle after
// acceptance, so the bus completes at most one access per two cycles and never stalls on a transfer.
module rapcores_spi_master
    import rapcores_spi_pkg::*;
#(
    parameter int WORD_BITS   = 64,
    parameter int DEFAULT_DIV = 4
) (
    input  logic        wb_clk_i,
    input  logic        resetn,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        spi_sck_o,
    output logic        spi_cs_o,
    output logic        spi_copi_o,
    input  logic        spi_cipo_i,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [MAX_WORD_BITS-1:0] TX_MASK = {MAX_WORD_BITS{1'b1}} >> (MAX_WORD_BITS - WORD_BITS);

    logic [MAX_WORD_BITS-1:0] tx_q, rx_ext;
    logic [WORD_BITS-1:0]     rx;
    logic [15:0]              clkdiv_q;
    logic [31:0]              rd_dat;
    logic [2:0]               adr_idx;
    logic                     acc, wr_acc, ctrl_wr, start, w1c, busy, done_pulse, done_q;
    logic                     unused_adr;

    assign unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};
    assign adr_idx    = wbs_adr_i[4:2];
    assign acc        = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wr_acc     = acc & wbs_we_i;
    assign ctrl_wr    = wr_acc & (adr_idx == REG_CTRL) & wbs_sel_i[0];
    assign start      = ctrl_wr & wbs_dat_i[CTRL_START] & ~busy;
    assign w1c        = ctrl_wr & wbs_dat_i[CTRL_DONE];
    assign rx_ext     = MAX_WORD_BITS'(rx);
    assign busy_o     = busy;
    assign done_o     = done_q;

    always_comb begin
        rd_dat = '0;
        case (adr_idx)
            REG_CTRL: begin
                rd_dat[CTRL_START] = busy;
                rd_dat[CTRL_DONE]  = done_q;
            end
            REG_TX0:    rd_dat = tx_q[31:0];
            REG_TX1:    rd_dat = tx_q[63:32];
            REG_RX0:    rd_dat = rx_ext[31:0];
            REG_RX1:    rd_dat = rx_ext[63:32];
            REG_CLKDIV: rd_dat = {16'd0, clkdiv_q};
            default:    rd_dat = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!resetn) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            tx_q      <= '0;
            clkdiv_q  <= 16'(DEFAULT_DIV);
            done_q    <= 1'b0;
        end else begin
            wbs_ack_o <= acc;
            if (acc)
                wbs_dat_o <= wbs_we_i ? 32'd0 : rd_dat;
            // a completion landing in the same cycle as a clear keeps the flag set
            done_q <= done_pulse | (done_q & ~w1c);
            if (wr_acc) begin
                case (adr_idx)
                    REG_TX0: tx_q[31:0]  <= merge_bytes(tx_q[31:0], wbs_dat_i, wbs_sel_i) & TX_MASK[31:0];
                    REG_TX1: tx_q[63:32] <= merge_bytes(tx_q[63:32], wbs_dat_i, wbs_sel_i) & TX_MASK[63:32];
                    REG_CLKDIV: begin
                        if (wbs_sel_i[0]) clkdiv_q[7:0]  <= wbs_dat_i[7:0];
                        if (wbs_sel_i[1]) clkdiv_q[15:8] <= wbs_dat_i[15:8];
                    end
                    default: ;
                endcase
            end
        end
    end

    rapcores_spi_shifter #(.WORD_BITS(WORD_BITS)) u_shifter (
        .wb_clk_i   (wb_clk_i),
        .resetn     (resetn),
        .start      (start),
        .tx         (tx_q[WORD_BITS-1:0]),
        .div        (clkdiv_q),
        .spi_cipo_i (spi_cipo_i),
        .busy       (busy),
        .rx         (rx),
        .done_pulse (done_pulse),
        .spi_sck_o  (spi_sck_o),
        .spi_cs_o   (spi_cs_o),
        .spi_copi_o (spi_copi_o)
    );

endmodule

// File: tb/tb_rapcores_spi_master.sv
// Bench for rapcores_spi_master: random words checked against an ideal SPI loopback model.
module tb_rapcores_spi_master;
    import rapcores_spi_pkg::*;

    logic        wb_clk_i = 1'b0;
    logic        resetn = 1'b0;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        spi_sck_o, spi_cs_o, spi_copi_o, spi_cipo_i;
    logic        busy_o, done_o;
    int          cipo_mode = 0;   // 0 loopback, 1 inverted loopback, 2 tied high

    int checks = 0, failures = 0;
    int rises = 0, busy_cycles = 0, dones = 0;
    logic [63:0] copi_seen = '0;

    always #5 wb_clk_i = ~wb_clk_i;

    assign spi_cipo_i = (cipo_mode == 0) ? spi_copi_o : (cipo_mode == 1) ? ~spi_copi_o : 1'b1;

    rapcores_spi_master dut (
        .wb_clk_i(wb_clk_i), .resetn(resetn),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .spi_sck_o(spi_sck_o), .spi_cs_o(spi_cs_o), .spi_copi_o(spi_copi_o),
        .spi_cipo_i(spi_cipo_i), .busy_o(busy_o), .done_o(done_o)
    );

    always @(posedge spi_sck_o) begin
        rises++;
        copi_seen = {copi_seen[62:0], spi_copi_o};
    end
    always @(negedge wb_clk_i) if (busy_o) busy_cycles++;
    always @(posedge done_o) dones++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_cycle(input logic [2:0] r, input logic we, input logic [31:0] d,
                            input logic [3:0] sel, output logic [31:0] q);
        bit got = 0;
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
        wbs_adr_i = {27'd0, r, 2'b00}; wbs_dat_i = d; wbs_sel_i = sel;
        for (int i = 0; i < 8; i++) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o) begin got = 1; break; end
        end
        q = wbs_dat_o;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
        if (!got) check("wb_ack_timeout", 0, 1);
    endtask

    task automatic wr(input logic [2:0] r, input logic [31:0] d, input logic [3:0] sel = 4'hF);
        logic [31:0] q;
        wb_cycle(r, 1'b1, d, sel, q);
    endtask

    task automatic rd(input logic [2:0] r, output logic [31:0] q);
        wb_cycle(r, 1'b0, 32'd0, 4'hF, q);
    endtask

    task automatic wait_done(input int limit);
        bit seen = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge wb_clk_i);
            if (done_o) begin seen = 1; break; end
        end
        if (!seen) check("done_timeout", 0, 1);
        repeat (2) @(posedge wb_clk_i);
        #1;
    endtask

    task automatic wait_rises(input int target);
        for (int i = 0; i < 5000 && rises < target; i++) @(negedge wb_clk_i);
        if (rises < target) check("sck_rise_timeout", 64'(rises), 64'(target));
    endtask

    // Ideal SPI peer: whatever the peer returns on CIPO, one bit per SCK, lands MSB-first in RX.
    function automatic logic [63:0] model_rx(input logic [63:0] tx, input int mode);
        if (mode == 0) return tx;
        if (mode == 1) return ~tx;
        return '1;
    endfunction

    task automatic load(input logic [15:0] div, input logic [63:0] tx);
        wr(REG_CLKDIV, {16'd0, div});
        wr(REG_TX0, tx[31:0]);
        wr(REG_TX1, tx[63:32]);
    endtask

    task automatic check_result(input string tag, input logic [63:0] tx, input int mode,
                                input int div, input int r0, input int b0, input int d0);
        logic [31:0] lo, hi;
        check({tag, "_sck_rises"}, 64'(rises - r0), 64);
        check({tag, "_busy_cycles"}, 64'(busy_cycles - b0), 64'((div + 1) * 130));
        check({tag, "_done_count"}, 64'(dones - d0), 1);
        check({tag, "_copi_bits"}, copi_seen, tx);
        check({tag, "_cs_idle"}, spi_cs_o, 1);
        rd(REG_RX0, lo);
        rd(REG_RX1, hi);
        check({tag, "_rx"}, {hi, lo}, model_rx(tx, mode));
    endtask

    task automatic xfer(input string tag, input logic [15:0] div, input logic [63:0] tx, input int mode);
        int r0, b0, d0;
        cipo_mode = mode;
        load(div, tx);
        r0 = rises; b0 = busy_cycles; d0 = dones;
        wr(REG_CTRL, 32'h3, 4'h1);
        check({tag, "_done_cleared"}, done_o, 0);
        check({tag, "_busy_after_start"}, busy_o, 1);
        wait_done((int'(div) + 1) * 130 + 20);
        check_result(tag, tx, mode, int'(div), r0, b0, d0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q, old_v, new_v, exp_v;
        logic [3:0]  sel;
        logic [63:0] tx_a;
        int          r0, b0, d0;

        // reset state
        repeat (2) @(posedge wb_clk_i);
        #1;
        check("rst_cs", spi_cs_o, 1);
        check("rst_sck", spi_sck_o, 0);
        check("rst_copi", spi_copi_o, 0);
        check("rst_ack", wbs_ack_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        resetn = 1;
        rd(REG_CLKDIV, q); check("rst_clkdiv", q, 4);
        rd(REG_TX0, q);    check("rst_tx0", q, 0);
        rd(REG_RX0, q);    check("rst_rx0", q, 0);

        xfer("loopback", 16'd0, 64'h01234567_89ABCDEF, 0);
        xfer("msb_first", 16'd0, 64'h80000000_00000000, 2);

        for (int i = 0; i < 4; i++)
            xfer("random", 16'($urandom_range(0, 3)), {$urandom, $urandom}, $urandom_range(0, 1));

        // START while busy is ignored; TX writes during a transfer do not disturb it
        tx_a = {$urandom, $urandom};
        cipo_mode = 0;
        load(16'd1, tx_a);
        r0 = rises; b0 = busy_cycles; d0 = dones;
        wr(REG_CTRL, 32'h3, 4'h1);
        wait_rises(r0 + 10);
        exp_v = $urandom;
        wr(REG_TX0, exp_v);
        wr(REG_CTRL, 32'h1, 4'h1);
        wait_done(400);
        check_result("busy_guard", tx_a, 0, 1, r0, b0, d0);
        rd(REG_TX0, q); check("busy_guard_tx0_updated", q, exp_v);

        // reset in the middle of a transfer
        load(16'd0, {$urandom, $urandom});
        r0 = rises;
        wr(REG_CTRL, 32'h3, 4'h1);
        wait_rises(r0 + 20);
        @(posedge wb_clk_i); #1;
        resetn = 0;
        @(posedge wb_clk_i); #1;
        check("midrst_cs", spi_cs_o, 1);
        check("midrst_sck", spi_sck_o, 0);
        check("midrst_busy", busy_o, 0);
        resetn = 1;
        rd(REG_RX0, q); check("midrst_rx0", q, 0);
        rd(REG_RX1, q); check("midrst_rx1", q, 0);
        xfer("after_reset", 16'($urandom_range(0, 2)), {$urandom, $urandom}, 1);

        // bus rules
        wr(REG_TX0, 32'h0);
        wr(REG_TX0, 32'hFFFF_FFFF, 4'b0001);
        rd(REG_TX0, q); check("sel_lane0", q, 32'h0000_00FF);
        for (int i = 0; i < 4; i++) begin
            old_v = $urandom; new_v = $urandom; sel = 4'($urandom_range(0, 15));
            wr(REG_TX1, old_v);
            wr(REG_TX1, new_v, sel);
            for (int b = 0; b < 4; b++)
                exp_v[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
            rd(REG_TX1, q); check("sel_random", q, exp_v);
        end
        wr(3'd6, 32'hDEAD_BEEF);
        rd(3'd6, q); check("unmapped6", q, 0);
        rd(3'd7, q); check("unmapped7", q, 0);
        @(posedge wb_clk_i); #1;
        check("ack_one_cycle", wbs_ack_o, 0);
        wr(REG_CLKDIV, 32'hFFFF_0003);
        rd(REG_CLKDIV, q); check("clkdiv_16bit", q, 3);
        rd(REG_CTRL, q); check("status_done", q, 32'h2);
        wr(REG_CTRL, 32'h2, 4'h1);
        check("w1c_done", done_o, 0);
        rd(REG_CTRL, q); check("status_clear", q, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
